fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, meaning number of write requesters (2..8).
REQ-002 Parameter DATA_W, default 8, meaning width of one FIFO word.
REQ-003 clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 req_i  input  NUM_REQ  per-requester write request; level; held until matching ack_o.
REQ-006 data_i  input  NUM_REQ*DATA_W  per-requester word; requester k occupies bits [k*DATA_W +: DATA_W]; stable while req_i[k] high.
REQ-007 fifo_full_i  input  1  shared sync FIFO full flag.
REQ-008 fifo_afull_i  input  1  shared FIFO almost-full flag (count >= DEPTH-1).
REQ-009 fifo_wr_en_o  output  1  registered FIFO write strobe.
REQ-010 fifo_wr_data_o  output  DATA_W  registered FIFO write data.
REQ-011 ack_o  output  NUM_REQ  registered one-hot, one-cycle pulse; coincides with fifo_wr_en_o for the granted requester.
REQ-012 grant_id_o  output  ID_W  index of the requester written this cycle; valid only while fifo_wr_en_o is high.
REQ-013 busy_o  output  1  registered OR of req_i masked by the current ack_o.

Function
REQ-014 Eligible set in cycle N = req_i AND NOT ack_o (the requester being acked is excluded from that cycle's arbitration).
REQ-015 Issue allowed in cycle N iff eligible set non-empty AND fifo_full_i low AND NOT (fifo_wr_en_o high AND fifo_afull_i high).
REQ-016 Selection is round-robin: search starts at index (last_grant + 1) mod NUM_REQ and picks the first eligible index upward with wrap.
REQ-017 Latency: a decision in cycle N produces fifo_wr_en_o, fifo_wr_data_o, ack_o and grant_id_o in cycle N+1; exactly one cycle.
REQ-018 last_grant updates only when an issue occurs; it holds when no issue occurs (idle or full).
REQ-019 Without an issue in cycle N, fifo_wr_en_o and ack_o are 0 in N+1; fifo_wr_data_o holds its previous value.
REQ-020 Throughput: one write per cycle sustained while allowed; with all requesters continuously active, grants rotate 0,1,2,...,NUM_REQ-1,0,...
REQ-021 A single continuously re-requesting requester is written at most every second cycle (REQ-014 masking); other eligible requesters fill the gaps.
REQ-022 fifo_full_i high: no issue; pending requests wait with no loss and no duplication.
REQ-023 Requester protocol: the requester drops req_i[k] or presents new data in the cycle after its ack_o[k] pulse.
REQ-024 The block never asserts fifo_wr_en_o in a cycle where the write would exceed FIFO capacity, given REQ-015.

Reset
REQ-025 While rst_i is high at a clock edge: fifo_wr_en_o=0, ack_o=0, grant_id_o=0, fifo_wr_data_o=0, busy_o=0, last_grant=NUM_REQ-1 (first search starts at index 0).
REQ-026 Reset asserted mid-operation discards the in-flight decision; no write or ack is issued in the cycle after the reset edge.
REQ-027 The first issue is possible in the first cycle rst_i is low; its outputs appear one cycle later.

Structure
REQ-028 Package fifo_arb_pkg holds NUM_REQ and DATA_W defaults, ID_W = clog2(NUM_REQ), and the round-robin rotate/priority function.
REQ-029 Sub-module rr_pick: combinational; inputs eligible vector and start index; outputs found flag and chosen index; instantiated once.
REQ-030 All outputs are driven directly from flops; no combinational path from any input to any output.

Verification
REQ-031 Reset: hold rst_i 2 cycles with req_i=4'b1111 -> all outputs 0 during reset; first ack_o=4'b0001 two edges after rst_i falls.
REQ-032 All-request rotation: req_i=4'b1111, data k=8'hA0+k, FIFO empty -> writes A0,A1,A2,A3,A0 on consecutive cycles.
REQ-033 Single requester: only req_i[2] held high -> ack_o[2] pulses every second cycle; no double write of one word.
REQ-034 Full back-pressure: assert fifo_full_i for 5 cycles with req_i=4'b0011 -> no fifo_wr_en_o; after release, grants resume at last_grant+1.
REQ-035 Almost-full: fifo_afull_i=1 with a write in progress -> no issue in that cycle; the next write is issued only after fifo_afull_i=0 or fifo_wr_en_o=0.
REQ-036 Reset mid-burst: rst_i pulsed for 1 cycle during REQ-032 -> no ack in the following cycle; rotation restarts at requester 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the round-robin FIFO write arbiter.
// Holds the default sizing and the rotate-and-pick search used by rr_pick.
package fifo_arb_pkg;

  // Default number of write requesters and FIFO word width
  localparam int NUM_REQ_DEFAULT = 4;
  localparam int DATA_W_DEFAULT  = 8;
  localparam int ID_W_DEFAULT    = $clog2(NUM_REQ_DEFAULT);

  // Widest requester vector the search function has to handle
  localparam int MAX_REQ = 8;

  typedef logic [MAX_REQ-1:0] req_vec_t;

  // Rotate the request vector so the search begins at 'start', then return
  // the first set index going upward with wrap, or -1 when nothing is set.
  // Only the low 'num_req' bits of 'eligible' are considered.
  function automatic int rr_rotate_pick(input req_vec_t eligible,
                                        input int       start,
                                        input int       num_req);
    int chosen;
    int cand;
    chosen = -1;
    for (int off = 0; off < MAX_REQ; off++) begin
      cand = (start + off) % num_req;
      if ((off < num_req) && (chosen < 0) && eligible[cand[2:0]]) begin
        chosen = cand;
      end
    end
    return chosen;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: finds the first eligible requester at or
// above the start index, wrapping around the top of the vector.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [ID_W-1:0]    start,
  output logic               found,
  output logic [ID_W-1:0]    index
);

  int chosen;

  // Search the eligible set from the start index and report the winner
  always_comb begin
    chosen = rr_rotate_pick(MAX_REQ'(eligible), int'(start), NUM_REQ);
    found  = (chosen >= 0);
    index  = found ? ID_W'(chosen) : '0;
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter in front of a shared synchronous FIFO.
// Each cycle one eligible requester may be chosen; the resulting write strobe,
// data, ack pulse and grant id all appear from flops one cycle later.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEFAULT,
  parameter  int DATA_W  = DATA_W_DEFAULT,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  input  logic                      fifo_full_i,
  input  logic                      fifo_afull_i,
  output logic                      fifo_wr_en_o,
  output logic [DATA_W-1:0]         fifo_wr_data_o,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic [ID_W-1:0]           grant_id_o,
  output logic                      busy_o
);

  logic [NUM_REQ-1:0] eligible;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    start_idx;
  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;
  logic               fifo_blocked;
  logic               issue;
  logic [NUM_REQ-1:0] next_ack;
  logic [DATA_W-1:0]  next_data;

  // A requester that is being acked right now still holds req_i high with
  // its old word, so it must sit out this cycle's arbitration.  The FIFO is
  // treated as unable to take another word when it is full, or when it is
  // almost full and the write currently on the bus will use the last slot.
  always_comb begin
    eligible     = req_i & ~ack_o;
    fifo_blocked = fifo_full_i | (fifo_wr_en_o & fifo_afull_i);
    start_idx    = (last_grant == ID_W'(NUM_REQ - 1)) ? '0 : last_grant + 1'b1;
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .eligible (eligible),
    .start    (start_idx),
    .found    (pick_found),
    .index    (pick_idx)
  );

  // Turn the picked index into the one-hot ack and the selected data word
  always_comb begin
    issue     = pick_found & ~fifo_blocked;
    next_ack  = '0;
    next_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == ID_W'(k)) begin
        next_ack[k] = issue;
        next_data   = data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // Register the decision; data, grant id and round-robin pointer only move
  // when a write is actually issued
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fifo_wr_en_o   <= 1'b0;
      fifo_wr_data_o <= '0;
      ack_o          <= '0;
      grant_id_o     <= '0;
      busy_o         <= 1'b0;
      last_grant     <= ID_W'(NUM_REQ - 1);
    end else begin
      fifo_wr_en_o <= issue;
      ack_o        <= next_ack;
      busy_o       <= |eligible;
      if (issue) begin
        fifo_wr_data_o <= next_data;
        grant_id_o     <= pick_idx;
        last_grant     <= pick_idx;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: a behavioural reference model predicts every output
// each cycle, a few directed scenarios pin known values, and a randomized
// phase drives requesters and a small FIFO occupancy model.
module tb_fifo_wr_arb;

  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 8;
  localparam int ID_W       = 2;
  localparam int FIFO_DEPTH = 4;

  logic                      clk_i = 1'b0;
  logic                      rst_i;
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*DATA_W-1:0] data_i;
  logic                      fifo_full_i;
  logic                      fifo_afull_i;
  logic                      fifo_wr_en_o;
  logic [DATA_W-1:0]         fifo_wr_data_o;
  logic [NUM_REQ-1:0]        ack_o;
  logic [ID_W-1:0]           grant_id_o;
  logic                      busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: what the outputs must be in the current cycle
  logic               exp_wr;
  logic [NUM_REQ-1:0] exp_ack;
  logic [DATA_W-1:0]  exp_data;
  logic [ID_W-1:0]    exp_grant;
  logic               exp_busy;
  int                 m_last;

  // random-phase environment state
  logic               rand_mode = 1'b0;
  int                 fifo_cnt  = 0;
  logic               prev_wr   = 1'b0;
  logic               pop       = 1'b0;
  int                 pop_pct   = 50;
  logic [NUM_REQ-1:0] ack_pend  = '0;

  fifo_wr_arb #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_i          (req_i),
    .data_i         (data_i),
    .fifo_full_i    (fifo_full_i),
    .fifo_afull_i   (fifo_afull_i),
    .fifo_wr_en_o   (fifo_wr_en_o),
    .fifo_wr_data_o (fifo_wr_data_o),
    .ack_o          (ack_o),
    .grant_id_o     (grant_id_o),
    .busy_o         (busy_o)
  );

  // free-running clock, 10 time units per period
  initial forever #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: from the inputs seen at this edge and the outputs of
  // the cycle that is ending, decide who (if anyone) gets written next
  always @(posedge clk_i) begin : ref_model
    int  pick;
    int  k;
    logic any_waiting;
    if (rst_i) begin
      exp_wr    = 1'b0;
      exp_ack   = '0;
      exp_data  = '0;
      exp_grant = '0;
      exp_busy  = 1'b0;
      m_last    = NUM_REQ - 1;
    end else begin
      pick        = -1;
      any_waiting = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_i[ID_W'(i)] && !exp_ack[ID_W'(i)]) any_waiting = 1'b1;
      end
      if (!fifo_full_i && !(exp_wr && fifo_afull_i)) begin
        for (int off = 1; off <= NUM_REQ; off++) begin
          k = (m_last + off) % NUM_REQ;
          if (pick < 0 && req_i[ID_W'(k)] && !exp_ack[ID_W'(k)]) pick = k;
        end
      end
      exp_busy = any_waiting;
      if (pick >= 0) begin
        exp_wr             = 1'b1;
        exp_ack            = '0;
        exp_ack[ID_W'(pick)] = 1'b1;
        exp_data           = data_i[pick*DATA_W +: DATA_W];
        exp_grant          = ID_W'(pick);
        m_last             = pick;
      end else begin
        exp_wr  = 1'b0;
        exp_ack = '0;
      end
    end
  end

  // Compare every output against the model half a cycle after each edge
  always @(negedge clk_i) begin
    check("wr_en",   32'(fifo_wr_en_o),   32'(exp_wr));
    check("ack",     32'(ack_o),          32'(exp_ack));
    check("busy",    32'(busy_o),         32'(exp_busy));
    check("wr_data", 32'(fifo_wr_data_o), 32'(exp_data));
    if (exp_wr) check("grant_id", 32'(grant_id_o), 32'(exp_grant));
  end

  // Advance one clock; in random mode also play the FIFO and the requesters
  task automatic step();
    int dec;
    @(posedge clk_i);
    #1;
    if (rand_mode) begin
      dec      = (pop && fifo_cnt > 0) ? 1 : 0;
      fifo_cnt = fifo_cnt + (prev_wr ? 1 : 0) - dec;
      check("fifo_overflow", 32'(fifo_cnt > FIFO_DEPTH), 32'(0));
      prev_wr      = fifo_wr_en_o;
      pop          = ($urandom_range(0, 99) < pop_pct);
      fifo_full_i  = (fifo_cnt >= FIFO_DEPTH);
      fifo_afull_i = (fifo_cnt >= FIFO_DEPTH - 1);
      for (int r = 0; r < NUM_REQ; r++) begin
        if (ack_pend[ID_W'(r)]) begin
          if ($urandom_range(0, 1) == 0) req_i[ID_W'(r)] = 1'b0;
          else data_i[r*DATA_W +: DATA_W] = DATA_W'($urandom);
        end else if (!req_i[ID_W'(r)] && $urandom_range(0, 99) < 40) begin
          req_i[ID_W'(r)] = 1'b1;
          data_i[r*DATA_W +: DATA_W] = DATA_W'($urandom);
        end
      end
      ack_pend = ack_o;
      if (rst_i) rst_i = 1'b0;
      else if ($urandom_range(0, 199) == 0) rst_i = 1'b1;
    end
  endtask

  // Put a fixed word A0+k on every requester lane
  task automatic apply_stimulus_words();
    for (int r = 0; r < NUM_REQ; r++) data_i[r*DATA_W +: DATA_W] = DATA_W'(32'hA0 + r);
  endtask

  initial begin
    rst_i        = 1'b1;
    req_i        = 4'b1111;
    data_i       = '0;
    fifo_full_i  = 1'b0;
    fifo_afull_i = 1'b0;
    apply_stimulus_words();

    // reset held for two edges with all requesters active
    for (int i = 0; i < 2; i++) begin
      step();
      check("reset_wr_en", 32'(fifo_wr_en_o), 32'(0));
      check("reset_ack",   32'(ack_o),        32'(0));
      check("reset_grant", 32'(grant_id_o),   32'(0));
      check("reset_data",  32'(fifo_wr_data_o), 32'(0));
      check("reset_busy",  32'(busy_o),       32'(0));
    end
    rst_i = 1'b0;
    step();
    check("first_ack",  32'(ack_o),          32'(4'b0001));
    check("first_data", 32'(fifo_wr_data_o), 32'(8'hA0));

    // all-request rotation continues A1, A2, A3, A0
    for (int i = 1; i <= 4; i++) begin
      step();
      check("rot_wr_en", 32'(fifo_wr_en_o),   32'(1));
      check("rot_data",  32'(fifo_wr_data_o), 32'(8'hA0 + (i % 4)));
      check("rot_ack",   32'(ack_o),          32'(1 << (i % 4)));
    end

    // one-cycle reset in the middle of the burst
    rst_i = 1'b1;
    step();
    check("midrst_wr_en", 32'(fifo_wr_en_o), 32'(0));
    check("midrst_ack",   32'(ack_o),        32'(0));
    rst_i = 1'b0;
    step();
    check("midrst_restart", 32'(ack_o), 32'(4'b0001));
    step();
    check("midrst_next",    32'(ack_o), 32'(4'b0010));

    // single requester: written every second cycle
    rst_i = 1'b1;
    req_i = 4'b0100;
    step();
    rst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("single_ack", 32'(ack_o), (i % 2 == 0) ? 32'(4'b0100) : 32'(0));
    end

    // full back-pressure for five cycles, then resume at last_grant+1
    rst_i = 1'b1;
    req_i = 4'b0011;
    step();
    rst_i = 1'b0;
    step();
    check("full_pre_ack", 32'(ack_o), 32'(4'b0001));
    fifo_full_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("full_no_wr", 32'(fifo_wr_en_o), 32'(0));
      check("full_busy",  32'(busy_o),       32'(1));
    end
    fifo_full_i = 1'b0;
    step();
    check("full_resume_ack",   32'(ack_o),      32'(4'b0010));
    check("full_resume_grant", 32'(grant_id_o), 32'(1));

    // almost-full: a write in flight blocks the next issue
    rst_i        = 1'b1;
    req_i        = 4'b1111;
    fifo_afull_i = 1'b1;
    step();
    rst_i = 1'b0;
    step();
    check("afull_first_wr",    32'(fifo_wr_en_o), 32'(1));
    check("afull_first_grant", 32'(grant_id_o),   32'(0));
    step();
    check("afull_gap",         32'(fifo_wr_en_o), 32'(0));
    step();
    check("afull_second_wr",   32'(fifo_wr_en_o), 32'(1));
    check("afull_second_grant", 32'(grant_id_o),  32'(1));
    fifo_afull_i = 1'b0;
    step();
    check("afull_clear_grant", 32'(grant_id_o),   32'(2));
    step();
    check("afull_clear_next",  32'(grant_id_o),   32'(3));

    // randomized traffic against a depth-4 FIFO occupancy model
    rst_i        = 1'b1;
    fifo_afull_i = 1'b0;
    fifo_full_i  = 1'b0;
    step();
    rst_i    = 1'b0;
    req_i    = NUM_REQ'($urandom);
    for (int r = 0; r < NUM_REQ; r++) data_i[r*DATA_W +: DATA_W] = DATA_W'($urandom);
    fifo_cnt  = 0;
    prev_wr   = 1'b0;
    pop       = 1'b0;
    ack_pend  = '0;
    rand_mode = 1'b1;
    pop_pct   = 80;
    repeat (1500) step();
    pop_pct   = 35;
    repeat (1500) step();
    rand_mode = 1'b0;
    rst_i     = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
